fire_alarm_ctrl: RTL and testbench

FIRE_ALARM_CTRL -- requirements
Module: fire_alarm_ctrl

---
 rtl/fire_alarm_pkg.sv | 20 ++
 rtl/fire_tick_gen.sv | 27 ++
 rtl/fire_alarm_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fire_alarm_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fire_alarm_pkg.sv
// Shared state encoding, parameter defaults and helpers for the flame-sensor alarm controller.
package fire_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_ALARM   = 2'd2,
    ST_CLEAR   = 2'd3
  } fa_state_t;

  localparam int DEF_SAMPLE_DIV  = 50000;
  localparam int DEF_CONFIRM_CNT = 8;
  localparam int DEF_BLINK_DIV   = 12500000;

  // Confirmation counter saturates at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fire_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, first tick DIV cycles after reset release.
module fire_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Flame-sensor alarm controller: debounced confirm/clear FSM with blinking lamp and mutable buzzer.
// Define FIRE_ALARM_LATCH_EN to keep a cleared alarm latched in CLEAR until the operator acknowledges.
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int CONFIRM_CNT = DEF_CONFIRM_CNT,
  parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       do_in,
  input  logic       ack,
  output logic       led,
  output logic       buzzer,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [7:0] CONFIRM_TARGET = 8'(CONFIRM_CNT);

  logic [1:0] sync_reg;
  logic       flame;
  logic       sample_tick;
  logic       blink_tick;
  logic       blink_rst;

  fa_state_t  state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next, cnt_inc;
  logic       mute_reg, mute_next;
  logic       led_reg, led_next;
  logic       buzzer_reg;
  logic       alarm_reg;
  logic       blink_hold_reg;
  logic       active_now, active_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], do_in};
    end
  end

  assign flame = ~sync_reg[1];

  fire_tick_gen #(.DIV(SAMPLE_DIV)) u_sample_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (sample_tick)
  );

  // The blink divider is held cleared by a registered flag while the alarm is inactive,
  // so every fresh alarm starts a full lamp half-period.
  assign blink_rst = rst | blink_hold_reg;

  fire_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
    .clk  (clk),
    .rst  (blink_rst),
    .tick (blink_tick)
  );

  assign cnt_inc     = sat_inc(cnt_reg);
  assign active_now  = (state_reg == ST_ALARM) || (state_reg == ST_CLEAR);
  assign active_next = (state_next == ST_ALARM) || (state_next == ST_CLEAR);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mute_next  = mute_reg;

    if (active_now && ack) begin
      mute_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (sample_tick && flame) begin
          if (CONFIRM_CNT == 1) begin
            state_next = ST_ALARM;
            cnt_next   = '0;
          end else begin
            state_next = ST_SUSPECT;
            cnt_next   = 8'd1;
          end
        end
      end
      ST_SUSPECT: begin
        if (sample_tick) begin
          if (!flame) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (cnt_inc >= CONFIRM_TARGET) begin
            state_next = ST_ALARM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      ST_ALARM: begin
        if (sample_tick) begin
          if (flame) begin
            cnt_next = '0;
          end else if (CONFIRM_CNT == 1) begin
`ifdef FIRE_ALARM_LATCH_EN
            state_next = ST_CLEAR;
            cnt_next   = 8'd1;
`else
            state_next = ST_IDLE;
            cnt_next   = '0;
`endif
          end else begin
            state_next = ST_CLEAR;
            cnt_next   = 8'd1;
          end
        end
      end
      ST_CLEAR: begin
`ifdef FIRE_ALARM_LATCH_EN
        // Once the clear count is reached only an acknowledge releases the alarm.
        if (ack && (cnt_reg >= CONFIRM_TARGET)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (sample_tick) begin
          if (flame) begin
            state_next = ST_ALARM;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
`else
        if (sample_tick) begin
          if (flame) begin
            state_next = ST_ALARM;
            cnt_next   = '0;
          end else if (cnt_inc >= CONFIRM_TARGET) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    // A fresh alarm always sounds; returning to idle forgets the mute.
    if (state_next == ST_IDLE || (!active_now && active_next)) begin
      mute_next = 1'b0;
    end
  end

  always_comb begin
    led_next = led_reg;
    if (!active_next) begin
      led_next = 1'b0;
    end else if (!active_now) begin
      led_next = 1'b1;
    end else if (blink_tick) begin
      led_next = ~led_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      mute_reg       <= 1'b0;
      led_reg        <= 1'b0;
      buzzer_reg     <= 1'b0;
      alarm_reg      <= 1'b0;
      blink_hold_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      mute_reg       <= mute_next;
      led_reg        <= led_next;
      buzzer_reg     <= active_next && !mute_next;
      alarm_reg      <= active_next;
      blink_hold_reg <= !active_next;
    end
  end

  assign led    = led_reg;
  assign buzzer = buzzer_reg;
  assign alarm  = alarm_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_fire_alarm_ctrl.sv
// Scoreboard bench: a streak-counting reference model queues expected output changes, a monitor checks them.
module tb_fire_alarm_ctrl;

  localparam int SDIV = 4;
  localparam int CC   = 3;
  localparam int BDIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       do_in = 1'b1;
  logic       ack = 1'b0;
  logic       led, buzzer, alarm;
  logic [1:0] state;

  fire_alarm_ctrl #(
    .SAMPLE_DIV  (SDIV),
    .CONFIRM_CNT (CC),
    .BLINK_DIV   (BDIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .do_in  (do_in),
    .ack    (ack),
    .led    (led),
    .buzzer (buzzer),
    .alarm  (alarm),
    .state  (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] vec;   // {state, alarm, led, buzzer}
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  // Reference model: alarm flag plus a streak of samples disagreeing with it.
  bit         m_h0, m_h1, m_a, m_mute, m_led;
  int         m_streak, m_edges, m_phase;
  logic [4:0] pub_vec  = 5'd0;
  logic [4:0] pub_base = 5'd0;
  int         pub_cyc  = -1;

  function automatic logic [4:0] model_vec();
    logic [1:0] st;
    if (m_a) st = (m_streak > 0) ? 2'd3 : 2'd2;
    else     st = (m_streak > 0) ? 2'd1 : 2'd0;
    return {st, m_a, m_led, m_a && !m_mute};
  endfunction

  // Only the last value within a cycle is observable, so same-cycle events are merged.
  task automatic publish();
    logic [4:0] v;
    v = model_vec();
    if (cyc != pub_cyc) begin
      pub_base = pub_vec;
      pub_cyc  = cyc;
    end
    if (exp_q.size() > 0 && exp_q[$].cyc == cyc) void'(exp_q.pop_back());
    if (v != pub_base) exp_q.push_back('{cyc, v});
    pub_vec = v;
  endtask

  task automatic model_reset();
    m_h0 = 1; m_h1 = 1; m_a = 0; m_mute = 0; m_led = 0;
    m_streak = 0; m_edges = 0; m_phase = 0;
    publish();
  endtask

  task automatic model_edge();
    bit flame, tick, was_a, exit_ack;
    flame = !m_h1;
    m_h1  = m_h0;
    m_h0  = do_in;
    m_edges++;
    tick     = (m_edges % SDIV) == 0;
    was_a    = m_a;
    exit_ack = 0;
`ifdef FIRE_ALARM_LATCH_EN
    if (m_a && m_streak >= CC && ack) begin
      m_a = 0; m_streak = 0; exit_ack = 1;
    end
`endif
    if (tick && !exit_ack) begin
      if (flame != m_a) begin
        m_streak = (m_streak < 255) ? m_streak + 1 : 255;
        if (m_streak >= CC) begin
`ifdef FIRE_ALARM_LATCH_EN
          if (!m_a) begin m_a = 1; m_streak = 0; end
`else
          m_a = !m_a; m_streak = 0;
`endif
        end
      end else begin
        m_streak = 0;
      end
    end
    if (was_a && ack) m_mute = 1;
    if (m_a != was_a) m_mute = 0;
    if (m_a && !was_a) begin
      m_led = 1; m_phase = 0;
    end else if (m_a) begin
      m_phase++;
      if (m_phase == BDIV) begin m_led = !m_led; m_phase = 0; end
    end else begin
      m_led = 0;
    end
    publish();
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step(input bit nd, input bit nack);
    @(posedge clk);
    cyc++;
    if (!rst) model_edge();
    #1;
    do_in = nd;
    ack   = nack;
  endtask

  // Called one time unit after an edge: reset lands mid-cycle and must act immediately.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_state",  int'(state),  0);
    chk("rst_alarm",  int'(alarm),  0);
    chk("rst_led",    int'(led),    0);
    chk("rst_buzzer", int'(buzzer), 0);
    step(do_in, 1'b0);
    step(do_in, 1'b0);
    rst = 1'b0;
  endtask

  // Monitor: every observed output change is one transaction.
  initial begin
    logic [4:0] prev, cur;
    ev_t e;
    prev = 5'd0;
    forever begin
      @(negedge clk);
      cur = {state, alarm, led, buzzer};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event: unexpected change at cyc %0d got %b expected no change", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.vec !== cur) begin
            failures++;
            $display("FAIL event: got cyc %0d vec %b expected cyc %0d vec %b", cyc, cur, e.cyc, e.vec);
          end else begin
            $display("event cyc=%0d state=%0d alarm=%0d led=%0d buzzer=%0d ok",
                     cyc, cur[4:3], cur[2], cur[1], cur[0]);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    pulse_reset();
    // Flame held from reset release: suspect, confirm, blink, then acknowledge.
    repeat (36) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (24) step(1'b0, 1'b0);
    // Flame gone for two ticks, then back: CLEAR returns to ALARM.
    repeat (9) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    // Full clear back to idle.
    repeat (20) step(1'b1, 1'b0);
    // Short burst that never confirms.
    repeat (8) step(1'b0, 1'b0);
    repeat (12) step(1'b1, 1'b0);
    // Re-enter alarm and reset in the middle of it.
    repeat (30) step(1'b0, 1'b0);
    pulse_reset();
    repeat (6) step(1'b1, 1'b0);

    for (int seg = 0; seg < 150; seg++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(2, 28);
      for (int i = 0; i < len; i++) begin
        step(v, $urandom_range(0, 24) == 0);
      end
      if (seg % 50 == 49) pulse_reset();
    end

    repeat (4) step(1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
